corescore_receiver_uart: RTL and testbench
==========================================

Name: corescore_receiver_uart

Overview:
UART receiver. It is the receive-side counterpart of the SoC's UART emitter and serves the RXD pin of the SOC. It oversamples the RX line using a clock-derived bit counter, deframes 8N1 characters LSB-first, and buffers complete bytes in a small first-word-fall-through FIFO. The FIFO presents bytes to the memory-mapped IO logic through a valid/ready handshake. Framing and overrun errors are reported through sticky flags.

Parameters:
clk_freq_hz, 27000000, system clock frequency in Hz.
baud_rate, 115200, line rate in bit/s.
fifo_depth, 4, receive FIFO depth in bytes; must be a power of 2, at least 2.
Derived values:
- CLKS_PER_BIT = clk_freq_hz / baud_rate, integer-truncated (234 at the defaults).
- HALF_BIT = CLKS_PER_BIT / 2, integer-truncated.

Ports:
i_clk  input  1  system clock.
i_rst  input  1  synchronous, active-high reset.
i_uart_rx  input  1  asynchronous serial line; idle level is 1.
o_data  output  8  byte at the FIFO head; valid only when o_valid=1.
o_valid  output  1  FIFO not empty.
i_ready  input  1  consumer accepts o_data; a pop occurs on any cycle with o_valid & i_ready.
o_busy  output  1  high whenever the FSM is not in IDLE.
o_frame_err  output  1  sticky: a stop bit was sampled as 0.
o_overrun  output  1  sticky: a byte was dropped because the FIFO was full.
i_clr_err  input  1  one-cycle pulse that clears o_frame_err and o_overrun.

Behaviour:
Reset and synchronisation:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset state: FSM in IDLE, counters 0, FIFO empty, both synchronizer flops set to 1.
- Reset values of outputs: o_valid=0, o_data=0, o_busy=0, o_frame_err=0, o_overrun=0.
- Reset mid-frame aborts the frame with no push and no error flag.
- Synchronizer: 2-flop synchronizer on i_uart_rx producing rx_s. All FSM decisions use rx_s only.

FSM (bit counter cnt, bit index idx 0..7, shift register sr):
- IDLE: when rx_s==0, set cnt<=0 and go to START.
- START: increment cnt. At cnt==HALF_BIT-1, sample rx_s.
  - rx_s==1 (glitch): return to IDLE.
  - rx_s==0: set cnt<=0, idx<=0, go to DATA.
- DATA: increment cnt. At cnt==CLKS_PER_BIT-1:
  - sr <= {rx_s, sr[7:1]} (LSB first), cnt<=0.
  - If idx==7, go to STOP; otherwise idx++.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: push sr to the FIFO (see FIFO rules), go to IDLE.
  - rx_s==0: set o_frame_err, discard sr, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A held break line therefore produces exactly one frame error, not repeated frames.
- Back-to-back frames: a start edge is accepted on the first IDLE cycle after STOP, so frames with no idle gap are received.

FIFO:
- First-word fall-through: o_data equals the head entry combinationally from registered storage. Read and write pointers wrap modulo fifo_depth.
- Push latency: o_valid rises on the cycle after the STOP sample cycle.
- Push when full with no pop that cycle: byte dropped, o_overrun<=1, FIFO contents unchanged.
- Push and pop in the same cycle: both take effect, including when full; no overrun and the count is unchanged.
- Pop when empty: impossible, since a pop requires o_valid.

Error flags:
- o_frame_err and o_overrun hold until i_clr_err.
- If i_clr_err coincides with a new error event, the new error wins and the flag stays set.

Width rules: cnt is wide enough to hold CLKS_PER_BIT-1; idx is 3 bits.

Test Plan:
- Setup: all scenarios use clk_freq_hz=16, baud_rate=1, giving CLKS_PER_BIT=16 and HALF_BIT=8.
- Send 0x55 as an 8N1 frame with i_ready=0 → o_valid=1 and o_data=0x55 after the stop sample; assert i_ready for 1 cycle → o_valid=0; no error flags.
- Drive rx low for 4 cycles then high → no push, o_busy returns to 0 within 12 cycles, flags stay 0.
- Send 0xA3 with stop bit 0 and hold rx low for 40 cycles → no push, o_frame_err=1. Release rx and send 0x3C → 0x3C received and o_frame_err still 1. Pulse i_clr_err → o_frame_err=0.
- fifo_depth=4, i_ready=0, send 0x01..0x05 → o_overrun=1 after the 5th frame; pops yield 0x01, 0x02, 0x03, 0x04, then o_valid=0.
- FIFO full, then pop on the exact cycle of the 5th push → no overrun; subsequent pops yield 0x02..0x05.
- Assert i_rst for 1 cycle during DATA idx=3 → all outputs at reset values. Then send 0xC4, then 0x00 and 0xFF back-to-back with no gap → 0xC4, 0x00, 0xFF received in order.

Source files
------------

// File: rtl/corescore_receiver_uart.sv
// 8N1 UART receiver: 2-flop synchronised RX line, mid-bit sampling FSM and a
// first-word-fall-through byte FIFO with valid/ready output and sticky error flags.
module corescore_receiver_uart #(
  parameter int clk_freq_hz = 27000000,
  parameter int baud_rate   = 115200,
  parameter int fifo_depth  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun,
  input  logic       i_clr_err
);

  localparam int CLKS_PER_BIT = clk_freq_hz / baud_rate;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW           = (fifo_depth > 2) ? $clog2(fifo_depth) : 1;

  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF_BIT - 1);
  localparam logic [AW:0]   FIFO_FULL    = (AW+1)'(fifo_depth);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  logic [1:0]    sync_r;
  logic          rx_s;
  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    sr_r;
  logic          busy_r;
  logic          frame_err_r;
  logic          overrun_r;

  logic [7:0]    mem_r [fifo_depth];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          valid_r;

  logic bit_end_s;
  logic stop_sample_s;
  logic push_s;
  logic frame_evt_s;
  logic pop_s;
  logic full_s;
  logic wr_en_s;
  logic overrun_evt_s;

  assign rx_s          = sync_r[1];
  assign bit_end_s     = (cnt_r == CNT_BIT_END);
  assign stop_sample_s = (state_r == ST_STOP) && bit_end_s;
  assign push_s        = stop_sample_s && rx_s;
  assign frame_evt_s   = stop_sample_s && !rx_s;
  assign pop_s         = valid_r && i_ready;
  assign full_s        = (count_r == FIFO_FULL);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en_s       = push_s && (!full_s || pop_s);
  assign overrun_evt_s = push_s && full_s && !pop_s;

  assign o_data      = mem_r[rd_ptr_r];
  assign o_valid     = valid_r;
  assign o_busy      = busy_r;
  assign o_frame_err = frame_err_r;
  assign o_overrun   = overrun_r;

  // Two-stage synchroniser for the asynchronous RX pin, idling high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], i_uart_rx};
    end
  end

  // Deframing FSM: start-bit validation at half a bit, then one sample per bit period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      sr_r    <= 8'h00;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt_r   <= '0;
            state_r <= ST_START;
            busy_r  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt_r == CNT_HALF_END) begin
            if (rx_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              cnt_r   <= '0;
              idx_r   <= 3'd0;
              state_r <= ST_DATA;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            sr_r  <= {rx_s, sr_r[7:1]};
            cnt_r <= '0;
            if (idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            cnt_r <= '0;
            if (rx_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_WAIT_HIGH;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new error event outranks a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (frame_evt_s) begin
        frame_err_r <= 1'b1;
      end else if (i_clr_err) begin
        frame_err_r <= 1'b0;
      end
      if (overrun_evt_s) begin
        overrun_r <= 1'b1;
      end else if (i_clr_err) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // Next FIFO occupancy from the push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_next_s = count_r + (AW+1)'(1);
      2'b01:   count_next_s = count_r - (AW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage and pointers; storage is cleared so o_data reads zero after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < fifo_depth; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= sr_r;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != '0);
    end
  end

endmodule

// File: tb/tb_corescore_receiver_uart.sv
// Scoreboard bench for corescore_receiver_uart: a queue-based line/FIFO model
// predicts every byte, valid level and error flag; a negedge monitor compares.
module tb_corescore_receiver_uart;

  localparam int CLK_HZ = 16;
  localparam int BAUD   = 1;
  localparam int DEPTH  = 4;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
  // Edges from driving the start bit to the stop-bit sample: synchroniser and
  // start detection (3), half a bit, then eight data bits plus the stop bit.
  localparam int PUSH_LAT = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       fe;
  logic       ovr;

  corescore_receiver_uart #(
    .clk_freq_hz(CLK_HZ),
    .baud_rate  (BAUD),
    .fifo_depth (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_uart_rx  (rx),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_busy     (busy),
    .o_frame_err(fe),
    .o_overrun  (ovr),
    .i_clr_err  (clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [7:0] b;
    logic       stop;
  } frame_t;

  frame_t     pend[$];
  frame_t     cur_f;
  logic [7:0] mq[$];
  logic       fe_m = 1'b0;
  logic       ovr_m = 1'b0;
  bit         full_m, pop_m, fev_m, oev_m;
  int         cyc = 0;
  int         dut_pops = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         rand_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    frame_t f;
    f.edge_no = cyc + PUSH_LAT;
    f.b = b;
    f.stop = stop;
    pend.push_back(f);
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(CPB);
    end
    rx = stop;
    step(CPB);
  endtask

  // Reference model: behavioural FIFO queue and error flags, advanced once per clock edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      pend.delete();
      fe_m = 1'b0;
      ovr_m = 1'b0;
    end else begin
      full_m = (mq.size() == DEPTH);
      pop_m = ready && (mq.size() != 0);
      fev_m = 1'b0;
      oev_m = 1'b0;
      if (pop_m) void'(mq.pop_front());
      if (pend.size() != 0 && pend[0].edge_no == cyc) begin
        cur_f = pend.pop_front();
        if (!cur_f.stop) fev_m = 1'b1;
        else if (full_m && !pop_m) oev_m = 1'b1;
        else mq.push_back(cur_f.b);
      end
      if (fev_m) fe_m = 1'b1;
      else if (clr) fe_m = 1'b0;
      if (oev_m) ovr_m = 1'b1;
      else if (clr) ovr_m = 1'b0;
    end
  end

  // Monitor: compares DUT outputs with the model mid-cycle, popping data on handshakes.
  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      check("valid", 32'(valid), 32'(mq.size() != 0));
      if (valid && ready) begin
        dut_pops++;
        if (mq.size() != 0) check("pop_data", 32'(data), 32'(mq[0]));
      end
      check("frame_err", 32'(fe), 32'(fe_m));
      check("overrun", 32'(ovr), 32'(ovr_m));
    end
  end

  // Random consumer and error-clear activity during the randomized phase.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_en) begin
      ready = ($urandom % 3) != 0;
      clr = ($urandom % 50) == 0;
    end
  end

  initial begin
    int p0, pe, n, gap;
    logic [7:0] b;
    logic stop;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step(1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fe", 32'(fe), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);

    // Single frame, held until the consumer takes it.
    send_frame(8'h55, 1'b1);
    step(2);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_data", 32'(data), 32'h55);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("t1_empty", 32'(valid), 32'd0);
    check("t1_fe", 32'(fe), 32'd0);
    check("t1_ovr", 32'(ovr), 32'd0);

    // Short low glitch is rejected at the half-bit check.
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    n = 0;
    while (busy && n < 12) begin
      step(1);
      n++;
    end
    check("t2_busy_idle", 32'(busy), 32'd0);
    check("t2_valid", 32'(valid), 32'd0);
    step(4);

    // Bad stop bit followed by a held break: one frame error only.
    send_frame(8'hA3, 1'b0);
    step(40);
    rx = 1'b1;
    step(8);
    check("t3_fe_set", 32'(fe), 32'd1);
    check("t3_no_push", 32'(valid), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1);
    step(2);
    check("t3_data", 32'(data), 32'h3C);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("t3_fe_sticky", 32'(fe), 32'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t3_fe_clr", 32'(fe), 32'd0);

    // Five bytes into a four-deep FIFO with no consumer.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    step(2);
    check("t4_ovr", 32'(ovr), 32'd1);
    check("t4_head", 32'(data), 32'h01);
    p0 = dut_pops;
    ready = 1'b1;
    step(8);
    ready = 1'b0;
    check("t4_pops", 32'(dut_pops - p0), 32'd4);
    check("t4_empty", 32'(valid), 32'd0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t4_ovr_clr", 32'(ovr), 32'd0);

    // Full FIFO, pop on the exact edge of the fifth push.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        #1;
        pe = pend[pend.size() - 1].edge_no;
        while (cyc < pe - 1) step(1);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
      end
    join
    step(2);
    check("t5_no_ovr", 32'(ovr), 32'd0);
    check("t5_head", 32'(data), 32'h02);
    p0 = dut_pops;
    ready = 1'b1;
    step(8);
    ready = 1'b0;
    check("t5_pops", 32'(dut_pops - p0), 32'd4);
    check("t5_empty", 32'(valid), 32'd0);

    // Reset during DATA (idx 3) with a byte queued and frame error set.
    send_frame(8'h77, 1'b1);
    send_frame(8'h11, 1'b0);
    rx = 1'b1;
    step(4);
    rx = 1'b0;
    step(CPB);
    b = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      step(CPB);
    end
    rx = b[3];
    step(2);
    check("t6_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    rx = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_valid", 32'(valid), 32'd0);
    check("t6_data", 32'(data), 32'h00);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_fe", 32'(fe), 32'd0);
    check("t6_ovr", 32'(ovr), 32'd0);
    step(4);
    send_frame(8'hC4, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    step(2);
    check("t6_head", 32'(data), 32'hC4);
    p0 = dut_pops;
    ready = 1'b1;
    step(8);
    ready = 1'b0;
    check("t6_pops", 32'(dut_pops - p0), 32'd3);
    check("t6_empty", 32'(valid), 32'd0);

    // Randomized frames, gaps, consumer stalls and error clears.
    rand_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      b = 8'($urandom);
      stop = ($urandom % 6) != 0;
      send_frame(b, stop);
      gap = stop ? int'($urandom_range(4, 0)) : int'($urandom_range(6, 2));
      rx = 1'b1;
      step(gap);
    end
    rx = 1'b1;
    rand_en = 1'b0;
    step(1);
    clr = 1'b0;
    ready = 1'b1;
    step(10);
    ready = 1'b0;
    check("rand_drained", 32'(valid), 32'd0);
    check("rand_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
